filter_accel_mac_pipe: RTL and testbench

Parametrised, pipelined multiply-accumulate engine for the filter accelerator datapath: signed sample × coefficient (coefficient signedness selectable), accumulated over a tap sequence delimited by first/last flags, then rounded, shifted and optionally saturated to the output width. Successor to the fixed 8×11 single-cycle multiplier. Adds configurable widths, pipeline depth, accumulation, valid/ready flow control and overflow reporting. Sits between the coefficient/sample fetch stage and the pixel write-back stage.

---
 rtl/filter_accel_mac_pipe_if.sv | 29 ++
 rtl/filter_accel_mac_pipe.sv | 115 +++++++++++
 tb/tb_filter_accel_mac_pipe.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_accel_mac_pipe_if.sv
// Beat and result channels between the fetch stage, the MAC pipe and pixel write-back.
// Handshake: a beat moves when in_valid & in_ready on a rising edge; a result moves
// when out_valid & out_ready on a rising edge. A valid side holds its payload until it moves.
interface filter_accel_mac_pipe_if #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 11,
    parameter int OUT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [A_WIDTH-1:0]   in_a;
    logic [B_WIDTH-1:0]   in_b;
    logic                 in_first;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/filter_accel_mac_pipe.sv
// Pipelined sample x coefficient multiply-accumulate over first/last-delimited tap
// sequences, with round, arithmetic shift, optional saturation and sticky overflow.
module filter_accel_mac_pipe #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 11,
    parameter int B_SIGNED  = 0,
    parameter int NUM_STAGE = 3,
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_SHIFT = 8,
    parameter int SATURATE  = 1
) (
    input logic clk,
    input logic reset,
    input logic ce,
    filter_accel_mac_pipe_if.slave bus
);
    localparam int PW = A_WIDTH + B_WIDTH + (B_SIGNED != 0 ? 0 : 1);
    localparam int L  = NUM_STAGE - 1;
    localparam logic signed [ACC_WIDTH:0] RND  = ((ACC_WIDTH+1)'(1) << OUT_SHIFT) >> 1;
    localparam logic signed [ACC_WIDTH:0] OMAX = ((ACC_WIDTH+1)'(1) << (OUT_WIDTH-1)) - (ACC_WIDTH+1)'(1);
    localparam logic signed [ACC_WIDTH:0] OMIN = ~OMAX;

    logic                        advance;
    logic                        accept;
    logic signed [PW-1:0]        a_ext, b_ext, prod;
    logic [NUM_STAGE-1:0]        vld_q, first_q, last_q;
    logic signed [PW-1:0]        prod_q [NUM_STAGE];
    logic signed [ACC_WIDTH-1:0] acc_q, acc_base, p_ext, sum_d;
    logic                        ovf_q, add_ovf, ovf_d, clip;
    logic signed [ACC_WIDTH:0]   rnd, shifted;
    logic [OUT_WIDTH-1:0]        res_d;
    logic                        out_valid_q, out_ovf_q;
    logic [OUT_WIDTH-1:0]        out_data_q;

    // No skid buffer: a held result stalls every stage, so readiness is purely combinational.
    assign advance       = ce & (~out_valid_q | bus.out_ready);
    assign accept        = bus.in_valid & advance;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;

    always_comb begin
        a_ext = PW'($signed(bus.in_a));
        if (B_SIGNED != 0) b_ext = PW'($signed(bus.in_b));
        else               b_ext = PW'(bus.in_b);
        prod = a_ext * b_ext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
        end else if (advance) begin
            vld_q[0]   <= accept;
            first_q[0] <= bus.in_first;
            last_q[0]  <= bus.in_last;
            prod_q[0]  <= prod;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
                prod_q[i]  <= prod_q[i-1];
            end
        end
    end

    // Rounding runs one bit wider than the accumulator so the half-LSB add cannot wrap.
    always_comb begin
        acc_base = first_q[L] ? '0 : acc_q;
        p_ext    = ACC_WIDTH'(prod_q[L]);
        sum_d    = acc_base + p_ext;
        add_ovf  = (acc_base[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                   (sum_d[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]);
        ovf_d    = (first_q[L] ? 1'b0 : ovf_q) | add_ovf;
        rnd      = (ACC_WIDTH+1)'(sum_d) + RND;
        shifted  = rnd >>> OUT_SHIFT;
        clip     = 1'b0;
        res_d    = shifted[OUT_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (shifted > OMAX) begin
                clip  = 1'b1;
                res_d = OMAX[OUT_WIDTH-1:0];
            end else if (shifted < OMIN) begin
                clip  = 1'b1;
                res_d = OMIN[OUT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else if (advance) begin
            if (vld_q[L]) begin
                acc_q <= sum_d;
                ovf_q <= ovf_d;
            end
            if (vld_q[L] && last_q[L]) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res_d;
                out_ovf_q   <= ovf_d | clip;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_filter_accel_mac_pipe.sv
// Bench for filter_accel_mac_pipe: three configurations fed identical beats, each
// compared against a tap-level arithmetic model with an expected-result queue.
module tb_filter_accel_mac_pipe;
    localparam int AW   = 8;
    localparam int BW   = 11;
    localparam int OW   = 16;
    localparam int ACCW = 24;
    localparam longint ACC_MOD = longint'(1) << ACCW;
    localparam longint ACC_MAX = (longint'(1) << (ACCW-1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) << (ACCW-1));
    localparam longint O_MAX   = (longint'(1) << (OW-1)) - 1;
    localparam longint O_MIN   = -(longint'(1) << (OW-1));

    logic          clk = 1'b0;
    logic          reset, ce, out_ready;
    logic          in_valid, in_first, in_last;
    logic [AW-1:0] in_a;
    logic [BW-1:0] in_b;

    int checks = 0;
    int errors = 0;

    filter_accel_mac_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) if0 ();
    filter_accel_mac_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) if1 ();
    filter_accel_mac_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) if2 ();

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
    assign if0.in_a     = in_a;      assign if1.in_a     = in_a;      assign if2.in_a     = in_a;
    assign if0.in_b     = in_b;      assign if1.in_b     = in_b;      assign if2.in_b     = in_b;
    assign if0.in_first = in_first;  assign if1.in_first = in_first;  assign if2.in_first = in_first;
    assign if0.in_last  = in_last;   assign if1.in_last  = in_last;   assign if2.in_last  = in_last;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

    filter_accel_mac_pipe dut0 (.clk(clk), .reset(reset), .ce(ce), .bus(if0));
    filter_accel_mac_pipe #(.OUT_SHIFT(0), .SATURATE(1)) dut1 (.clk(clk), .reset(reset), .ce(ce), .bus(if1));
    filter_accel_mac_pipe #(.OUT_SHIFT(0), .SATURATE(0)) dut2 (.clk(clk), .reset(reset), .ce(ce), .bus(if2));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint       m_acc = 0;
    bit           m_ovf = 1'b0;
    logic [OW:0]  exp_q0[$], exp_q1[$], exp_q2[$];

    function automatic logic [OW:0] model_out(longint acc, bit ovf, int shift, bit sat);
        longint r;
        longint half;
        bit     c = 1'b0;
        half = (shift > 0) ? (longint'(1) << (shift - 1)) : 0;
        r = (acc + half) >>> shift;
        if (sat) begin
            if (r > O_MAX)      begin r = O_MAX; c = 1'b1; end
            else if (r < O_MIN) begin r = O_MIN; c = 1'b1; end
        end
        return {ovf | c, r[OW-1:0]};
    endfunction

    function automatic void model_beat(logic [AW-1:0] a, logic [BW-1:0] b, bit f, bit l);
        longint p, x, w;
        p = longint'($signed(a)) * longint'(b);
        x = (f ? 0 : m_acc) + p;
        w = x;
        if (w > ACC_MAX)      w = w - ACC_MOD;
        else if (w < ACC_MIN) w = w + ACC_MOD;
        m_ovf = (f ? 1'b0 : m_ovf) | (w != x);
        m_acc = w;
        if (l) begin
            exp_q0.push_back(model_out(w, m_ovf, 8, 1'b1));
            exp_q1.push_back(model_out(w, m_ovf, 0, 1'b1));
            exp_q2.push_back(model_out(w, m_ovf, 0, 1'b0));
        end
    endfunction

    always @(posedge reset) begin
        m_acc = 0;
        m_ovf = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && in_valid && if0.in_ready)
            model_beat(in_a, in_b, in_first, in_last);
        if (!reset && ce && out_ready && if0.out_valid) begin
            check("result_expected", 32'(exp_q0.size() != 0), 1);
            if (exp_q0.size() != 0) begin
                check("res_shift8_sat", {if0.out_ovf, if0.out_data}, exp_q0.pop_front());
                check("res_shift0_sat", {if1.out_ovf, if1.out_data}, exp_q1.pop_front());
                check("res_shift0_trunc", {if2.out_ovf, if2.out_data}, exp_q2.pop_front());
            end
        end
    end

    // State must not move across an edge sampled with ce low.
    bit            freeze_on = 1'b0;
    logic          prev_ce = 1'b1;
    logic          prev_vld = 1'b0;
    logic [OW-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (freeze_on && !reset && prev_ce === 1'b0) begin
            check("ce_freeze_valid", if0.out_valid, prev_vld);
            check("ce_freeze_data", if0.out_data, prev_data);
        end
        prev_ce   = ce;
        prev_vld  = if0.out_valid;
        prev_data = if0.out_data;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int a, input int b, input bit f, input bit l);
        bit ok = 1'b0;
        in_a = AW'(a); in_b = BW'(b); in_first = f; in_last = l; in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (if0.in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("send_accepted", ok, 1);
    endtask

    task automatic wait_out(output logic [OW:0] r0, output logic [OW:0] r1, output logic [OW:0] r2);
        bit got = 1'b0;
        r0 = '0; r1 = '0; r2 = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (if0.out_valid) begin
                got = 1'b1;
                r0 = {if0.out_ovf, if0.out_data};
                r1 = {if1.out_ovf, if1.out_data};
                r2 = {if2.out_ovf, if2.out_data};
            end
        end
        check("result_arrived", got, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid();
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (if0.out_valid) got = 1'b1;
        end
        check("valid_seen", got, 1);
    endtask

    // ---------------- stimulus ----------------
    logic [OW:0]   r0, r1, r2;
    logic [OW-1:0] held;
    int            lat;

    initial begin
        reset = 1'b1; ce = 1'b1; out_ready = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", if0.out_valid, 0);
        check("rst_out_data", if0.out_data, 0);
        check("rst_out_ovf", if0.out_ovf, 0);
        check("rst_in_ready", if0.in_ready, ce);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single tap, latency and value
        send(-128, 2047, 1, 1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (if0.out_valid) begin lat = i; break; end
        end
        check("latency_edges", lat, 3);
        check("single_tap_data", if0.out_data, 16'hFC01);
        check("single_tap_ovf", if0.out_ovf, 0);
        @(posedge clk); #1;

        // Three taps then a back-to-back second sequence
        send(10, 100, 1, 0); send(-5, 200, 0, 0); send(3, 1000, 0, 1);
        send(1, 256, 1, 0);  send(2, 256, 0, 0);  send(3, 256, 0, 1);
        wait_out(r0, r1, r2);
        check("three_tap_data", r0[OW-1:0], 12);
        check("three_tap_ovf", r0[OW], 0);
        wait_out(r0, r1, r2);
        check("second_seq_data", r0[OW-1:0], 6);

        // Saturation and truncation configurations
        send(127, 2047, 1, 1);
        wait_out(r0, r1, r2);
        check("sat_pos_data", r1[OW-1:0], 16'h7FFF);
        check("sat_pos_ovf", r1[OW], 1);
        check("trunc_pos_data", r2[OW-1:0], 16'hF781);
        check("trunc_pos_ovf", r2[OW], 0);
        send(-128, 2047, 1, 1);
        wait_out(r0, r1, r2);
        check("sat_neg_data", r1[OW-1:0], 16'h8000);
        check("sat_neg_ovf", r1[OW], 1);

        // Accumulator wrap over 33 taps, then overflow cleared by first
        for (int i = 0; i < 33; i++) send(127, 2047, i == 0, i == 32);
        wait_out(r0, r1, r2);
        check("wrap_data", r0[OW-1:0], 16'h82E8);
        check("wrap_ovf", r0[OW], 1);
        send(1, 1, 1, 1);
        wait_out(r0, r1, r2);
        check("after_wrap_ovf", r0[OW], 0);

        // Backpressure with two results pending
        out_ready = 1'b0;
        send(1, 1000, 1, 1);
        send(2, 1000, 1, 1);
        wait_valid();
        held = if0.out_data;
        check("bp_first_data", held, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", if0.in_ready, 0);
            check("bp_data_stable", if0.out_data, held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_out(r0, r1, r2);
        check("bp_release_first", r0[OW-1:0], 4);
        wait_out(r0, r1, r2);
        check("bp_release_second", r0[OW-1:0], 8);
        repeat (3) @(posedge clk);
        #1;
        check("bp_queue_drained", exp_q0.size(), 0);

        // Clock-enable toggling
        freeze_on = 1'b1;
        fork
            begin
                repeat (60) begin
                    @(posedge clk); #1;
                    ce = 1'($urandom_range(0, 1));
                end
                ce = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++)
                    send(int'($urandom_range(0, 255)), int'($urandom_range(0, 2047)), i % 3 == 0, (i % 3 == 2) || (i == 7));
            end
        join
        repeat (10) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure and clock enable
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = AW'($urandom);
            in_b      = BW'($urandom);
            in_first  = ($urandom_range(0, 3) == 0);
            in_last   = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ce        = ($urandom_range(0, 7) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; ce = 1'b1; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("random_queue_drained", exp_q0.size(), 0);
        freeze_on = 1'b0;

        // Asynchronous reset mid-sequence
        out_ready = 1'b0;
        send(1, 256, 1, 1);
        send(5, 5, 1, 0);
        send(6, 6, 0, 0);
        wait_valid();
        check("pre_reset_data", if0.out_data, 1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_valid", if0.out_valid, 0);
        check("async_rst_data", if0.out_data, 0);
        check("async_rst_ovf", if0.out_ovf, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        send(2, 3, 0, 1);
        wait_out(r0, r1, r2);
        check("post_reset_data", r0[OW-1:0], 0);
        check("post_reset_ovf", r0[OW], 0);
        check("post_reset_exact", r1[OW-1:0], 6);
        repeat (5) @(posedge clk);
        #1;
        check("final_queue_drained", exp_q0.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
